// File: rtl/period_meter_if.sv
// Signal bundle for period_meter: configuration and pulse input in, measurement results out.
interface period_meter_if #(parameter int WIDTH = 32);
  logic             ENABLE;
  logic             PULSE_IN;
  logic             CONFIG_TIMEOUT;
  logic [WIDTH-1:0] DIN_TIMEOUT;
  logic [WIDTH-1:0] PERIOD;
  logic             VALID;
  logic             LOCKED;
  logic             TIMEOUT;

  modport master (
    output ENABLE, PULSE_IN, CONFIG_TIMEOUT, DIN_TIMEOUT,
    input  PERIOD, VALID, LOCKED, TIMEOUT
  );

  modport slave (
    input  ENABLE, PULSE_IN, CONFIG_TIMEOUT, DIN_TIMEOUT,
    output PERIOD, VALID, LOCKED, TIMEOUT
  );
endinterface

// File: rtl/period_meter.sv
// Measures the CLK-cycle spacing between rising edges of PULSE_IN, flags two equal
// consecutive periods (LOCKED) and a missing edge within a programmable window (TIMEOUT).
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | ENABLE low; counter/lock cleared, timeout register writable
// WAIT_FIRST | armed, waiting for the first edge to start counting
// MEASURE    | counting cycles since the last edge
module period_meter #(
  parameter int WIDTH = 32
) (
  input logic           CLK,
  input logic           RESET,
  period_meter_if.slave pm
);
  typedef enum logic [1:0] {IDLE, WAIT_FIRST, MEASURE} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] prev_period;
  logic [WIDTH-1:0] timeout_reg;
  logic             pulse_d;
  logic             have_prev;

  logic edge_evt;
  logic at_timeout;
  logic clr;
  logic load_first;
  logic measure;
  logic timeout_hit;

  assign edge_evt   = pm.PULSE_IN & ~pulse_d;
  assign at_timeout = (timeout_reg != '0) && (cnt == timeout_reg);

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // An edge coinciding with the timeout count is a measurement, so edge is tested first.
  always_comb begin
    state_nxt   = state;
    clr         = 1'b0;
    load_first  = 1'b0;
    measure     = 1'b0;
    timeout_hit = 1'b0;
    if (!pm.ENABLE) begin
      state_nxt = IDLE;
      clr       = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = WAIT_FIRST;
          clr       = 1'b1;
        end
        WAIT_FIRST: begin
          if (edge_evt) begin
            load_first = 1'b1;
            state_nxt  = MEASURE;
          end
        end
        MEASURE: begin
          if (edge_evt) begin
            measure = 1'b1;
          end else if (at_timeout) begin
            timeout_hit = 1'b1;
            state_nxt   = WAIT_FIRST;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pulse_d     <= 1'b0;
      cnt         <= '0;
      prev_period <= '0;
      have_prev   <= 1'b0;
      timeout_reg <= '0;
      pm.PERIOD   <= '0;
      pm.VALID    <= 1'b0;
      pm.LOCKED   <= 1'b0;
      pm.TIMEOUT  <= 1'b0;
    end else begin
      pulse_d    <= pm.PULSE_IN;
      pm.VALID   <= measure;
      pm.TIMEOUT <= timeout_hit;
      if (pm.CONFIG_TIMEOUT && !pm.ENABLE) timeout_reg <= pm.DIN_TIMEOUT;

      if (clr) begin
        cnt         <= '0;
        prev_period <= '0;
        have_prev   <= 1'b0;
        pm.LOCKED   <= 1'b0;
      end else if (load_first) begin
        cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
      end else if (measure) begin
        cnt         <= {{(WIDTH-1){1'b0}}, 1'b1};
        pm.PERIOD   <= cnt;
        prev_period <= cnt;
        have_prev   <= 1'b1;
        pm.LOCKED   <= have_prev && (cnt == prev_period);
      end else if (timeout_hit) begin
        // Lock history restarts: the next measurement after re-arming is a first one.
        cnt         <= '0;
        prev_period <= '0;
        have_prev   <= 1'b0;
        pm.LOCKED   <= 1'b0;
      end else if (state == MEASURE && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
